// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory bus initiator: FSM state encoding,
// response error codes and byte-to-word address conversion.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ALIGN   = 2'd1;
    localparam logic [1:0] ERR_EXC     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // The RAM is word addressed; dropping the two byte-select bits gives
    // {2'b00, addr[31:2]}.
    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/mem_master_if.sv
// Bundle of the CPU-side request/response port and the RAM-side strobe bus.
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; the requester must hold req_we/req_addr/req_wdata
// stable while req_valid is high. Exactly one response follows each accepted
// request as a one-cycle resp_valid pulse; there is no back-pressure on the
// response side.
//
// RAM side: read/write are level strobes held until rrdy/wrdy (one-cycle
// pulses) or an error ends the access. r_line is only meaningful while rrdy is
// high. exc is sticky in the RAM until its next successful access.
//
// state is a debug copy of the initiator FSM state.
interface mem_master_if;
    import mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] r_addr;
    logic [31:0] w_addr;
    logic [31:0] w_line;
    logic        read;
    logic        write;
    logic [31:0] r_line;
    logic        rrdy;
    logic        wrdy;
    logic        exc;
    state_t      state;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        input  r_line, rrdy, wrdy, exc,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output r_addr, w_addr, w_line, read, write,
        output state
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        output r_line, rrdy, wrdy, exc,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  r_addr, w_addr, w_line, read, write,
        input  state
    );

endinterface

// File: rtl/mem_master.sv
// Single-word bus initiator between the load/store stage and the data RAM.
// Checks alignment, drives the RAM strobes, decodes the RAM exception flag and
// enforces a per-transaction watchdog. One response per accepted request.
module mem_master
    import mem_pkg::*;
#(
    // Wait cycles allowed per access before reporting a timeout; must be >= 2.
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_master_if.master    bus
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hit;

    assign bus.state = state;

    // Completion pulse from the RAM for whichever access is in flight.
    always_comb begin
        hit = 1'b0;
        if (state == RD_WAIT) begin
            hit = bus.rrdy;
        end else if (state == WR_WAIT) begin
            hit = bus.wrdy;
        end
    end

    // Transaction FSM; all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= ERR_OK;
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.r_addr     <= '0;
            bus.w_addr     <= '0;
            bus.w_line     <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        cnt           <= '0;
                        if (bus.req_addr[1:0] != 2'b00) begin
                            // Misaligned: answer straight away, RAM untouched.
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= ERR_ALIGN;
                            bus.resp_rdata <= '0;
                        end else if (bus.req_we) begin
                            state      <= WR_WAIT;
                            bus.write  <= 1'b1;
                            bus.w_addr <= word_addr(bus.req_addr);
                            bus.w_line <= bus.req_wdata;
                        end else begin
                            state      <= RD_WAIT;
                            bus.read   <= 1'b1;
                            bus.r_addr <= word_addr(bus.req_addr);
                        end
                    end
                end

                RD_WAIT, WR_WAIT: begin
                    if (hit) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= ERR_OK;
                        bus.resp_rdata <= (state == RD_WAIT) ? bus.r_line : '0;
                        bus.read       <= 1'b0;
                        bus.write      <= 1'b0;
                    end else if (cnt != '0 && bus.exc) begin
                        // exc in wait cycle 0 is the previous access's stale flag.
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= ERR_EXC;
                        bus.resp_rdata <= '0;
                        bus.read       <= 1'b0;
                        bus.write      <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= ERR_TIMEOUT;
                        bus.resp_rdata <= '0;
                        bus.read       <= 1'b0;
                        bus.write      <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RESP: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                end

                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.read      <= 1'b0;
                    bus.write     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Directed plus randomized bench for mem_master with a behavioural RAM model
// and a reference model of the expected response, latency and strobe length.
module tb_mem_master;
    import mem_pkg::*;

    localparam int TIMEOUT   = 16;
    localparam int RAM_WORDS = 1024;

    logic clk;
    logic rst_n;

    mem_master_if bus ();

    mem_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [31:0] ram [0:RAM_WORDS-1];
    logic        rrdy_q, wrdy_q, exc_q;
    logic [31:0] line_q;
    logic        ram_silent;

    assign bus.rrdy   = rrdy_q;
    assign bus.wrdy   = wrdy_q;
    assign bus.exc    = exc_q;
    // Outside the rrdy cycle the data lines are not driven; model them as X.
    assign bus.r_line = rrdy_q ? line_q : 32'hxxxx_xxxx;

    always @(posedge clk) begin
        rrdy_q <= 1'b0;
        wrdy_q <= 1'b0;
        if (!ram_silent) begin
            if (bus.read && !rrdy_q) begin
                if (bus.r_addr < RAM_WORDS) begin
                    rrdy_q <= 1'b1;
                    line_q <= ram[bus.r_addr[9:0]];
                    exc_q  <= 1'b0;
                end else begin
                    exc_q <= 1'b1;
                end
            end else if (bus.write && !wrdy_q) begin
                if (bus.w_addr < RAM_WORDS) begin
                    wrdy_q <= 1'b1;
                    ram[bus.w_addr[9:0]] <= bus.w_line;
                    exc_q  <= 1'b0;
                end else begin
                    exc_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- strobe monitor ----------------
    int          rd_cycles;
    int          wr_cycles;
    logic [31:0] seen_w_addr;

    always @(negedge clk) begin
        if (bus.read)  rd_cycles = rd_cycles + 1;
        if (bus.write) begin
            wr_cycles   = wr_cycles + 1;
            seen_w_addr = bus.w_addr;
        end
    end

    // ---------------- scoreboard ----------------
    int          checks;
    int          errors;
    logic [33:0] exp_q[$];       // {err, rdata}
    logic [31:0] ref_mem [0:RAM_WORDS-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and check its response against the reference model.
    task automatic do_txn(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        logic [31:0] word;
        logic [1:0]  e_err;
        logic [31:0] e_data;
        int          e_lat, e_cyc, lat, guard;
        logic [33:0] e;

        word = addr >> 2;
        if (addr[1:0] != 2'b00) begin
            e_err = 2'd1; e_data = 0; e_lat = 1; e_cyc = 0;
        end else if (ram_silent) begin
            e_err = 2'd3; e_data = 0; e_lat = TIMEOUT + 1; e_cyc = TIMEOUT;
        end else if (word >= RAM_WORDS) begin
            e_err = 2'd2; e_data = 0; e_lat = 3; e_cyc = 2;
        end else begin
            e_err = 2'd0; e_lat = 3; e_cyc = 2;
            e_data = we ? 32'h0 : ref_mem[word[9:0]];
            if (we) ref_mem[word[9:0]] = wdata;
        end
        exp_q.push_back({e_err, e_data});

        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, ":ready_wait"}, 32'(guard < 50), 32'd1);

        rd_cycles = 0;
        wr_cycles = 0;
        seen_w_addr = 32'hFFFF_FFFF;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        lat = 0;
        while (lat <= 100) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid === 1'b1) break;
        end
        e = exp_q.pop_front();
        chk({tag, ":latency"}, 32'(lat), 32'(e_lat));
        chk({tag, ":err"},     32'(bus.resp_err), 32'(e[33:32]));
        chk({tag, ":rdata"},   bus.resp_rdata, e[31:0]);
        chk({tag, ":strobes_low"}, 32'({bus.read, bus.write}), 32'd0);
        chk({tag, ":rd_cycles"}, 32'(rd_cycles), we ? 32'd0 : 32'(e_cyc));
        chk({tag, ":wr_cycles"}, 32'(wr_cycles), we ? 32'(e_cyc) : 32'd0);
        if (we && e_cyc != 0) chk({tag, ":w_addr"}, seen_w_addr, word);

        @(negedge clk);
        chk({tag, ":pulse_one"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, ":ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          nresp;
        logic        we;
        logic [31:0] addr;
        int          kind;

        checks = 0;
        errors = 0;
        ram_silent = 1'b0;
        rrdy_q = 1'b0; wrdy_q = 1'b0; exc_q = 1'b0; line_q = '0;
        for (int i = 0; i < RAM_WORDS; i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Reset.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst:req_ready",  32'(bus.req_ready),  32'd1);
        chk("rst:resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst:resp_rdata", bus.resp_rdata,      32'd0);
        chk("rst:resp_err",   32'(bus.resp_err),   32'd0);
        chk("rst:strobes",    32'({bus.read, bus.write}), 32'd0);
        chk("rst:r_addr",     bus.r_addr, 32'd0);
        chk("rst:w_addr",     bus.w_addr, 32'd0);
        chk("rst:w_line",     bus.w_line, 32'd0);
        chk("rst:state",      32'(bus.state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back the same word.
        do_txn(1'b1, 32'h10, 32'hDEAD_BEEF, "wr10");
        do_txn(1'b0, 32'h10, 32'h0, "rd10");
        // Out-of-range read, then an immediate valid read with stale exc.
        do_txn(1'b0, 32'h1000, 32'h0, "rd_oor");
        do_txn(1'b0, 32'h10, 32'h0, "rd_after_oor");
        do_txn(1'b1, 32'h2000, 32'h1234_5678, "wr_oor");
        do_txn(1'b0, 32'h10, 32'h0, "rd_after_wr_oor");
        // Misaligned accesses.
        do_txn(1'b0, 32'h13, 32'h0, "rd_mis");
        do_txn(1'b1, 32'h22, 32'hCAFE_F00D, "wr_mis");
        // RAM that never answers.
        ram_silent = 1'b1;
        do_txn(1'b0, 32'h40, 32'h0, "rd_timeout");
        do_txn(1'b1, 32'h44, 32'h5555_AAAA, "wr_timeout");

        // Reset in the middle of a read wait.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h20;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort:read_before", 32'(bus.read), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort:read",       32'(bus.read),       32'd0);
        chk("abort:req_ready",  32'(bus.req_ready),  32'd1);
        chk("abort:resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("abort:state",      32'(bus.state),      32'(IDLE));
        rst_n = 1'b1;
        nresp = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) nresp++;
        end
        chk("abort:no_resp", 32'(nresp), 32'd0);
        ram_silent = 1'b0;

        // Randomized mix.
        for (int n = 0; n < 40; n++) begin
            we   = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            end else if (kind == 1) begin
                addr = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
            end else begin
                addr = 32'($urandom_range(0, 31)) << 2;
            end
            do_txn(we, addr, $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
